// File: rtl/account_mem_arbiter.sv
// account_mem_arbiter
//   Serialises three requesters (lock, balance update, balance read) onto a
//   single-port account memory. Each memory word is {locked, balance}.
//   Only one operation is in flight at a time. An operation reads the word,
//   computes the result, optionally writes it back, and then pulses its done.
//
// Ports
//   clk, rst                       clock, async active-high reset
//   lock_req/lock_id/lock_done     set the lock bit of an account
//   upd_req/upd_id/upd_amt/upd_wd  deposit (wd=0) or withdraw (wd=1)
//   upd_done/upd_ok                completion, ok=1 when written
//   rd_req/rd_id/rd_done           balance query
//   rd_bal/rd_locked               query result, held until the next rd_done
//   mem_en/mem_we/mem_addr         single-port memory control
//   mem_wdata/mem_rdata            memory data (rdata one cycle after read)
//
// State | meaning
//   IDLE  | sample requests, grant one
//   RD    | memory read of the latched account
//   CALC  | capture read word, compute result / reject
//   WR    | write back the new word
//   DONE  | one-cycle done pulse for the serviced requester

module account_mem_arbiter #(
    parameter int ACC_W = 4,
    parameter int BAL_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lock_req,
    input  logic [ACC_W-1:0] lock_id,
    output logic             lock_done,
    input  logic             upd_req,
    input  logic [ACC_W-1:0] upd_id,
    input  logic [BAL_W-1:0] upd_amt,
    input  logic             upd_wd,
    output logic             upd_done,
    output logic             upd_ok,
    input  logic             rd_req,
    input  logic [ACC_W-1:0] rd_id,
    output logic             rd_done,
    output logic [BAL_W-1:0] rd_bal,
    output logic             rd_locked,
    output logic             mem_en,
    output logic             mem_we,
    output logic [ACC_W-1:0] mem_addr,
    output logic [BAL_W:0]   mem_wdata,
    input  logic [BAL_W:0]   mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CALC = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_LOCK = 2'd0,
        OP_UPD  = 2'd1,
        OP_RD   = 2'd2
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [ACC_W-1:0] id_q, id_d;
    logic [BAL_W-1:0] amt_q, amt_d;
    logic             wd_q, wd_d;
    // 0 = update wins a tie with read, 1 = read wins
    logic             rr_q, rr_d;
    logic [BAL_W:0]   wdata_q, wdata_d;
    logic             ok_q, ok_d;
    logic [BAL_W-1:0] rd_bal_q, rd_bal_d;
    logic             rd_locked_q, rd_locked_d;

    logic             old_locked;
    logic [BAL_W-1:0] old_bal;
    logic [BAL_W:0]   sum;
    logic [BAL_W-1:0] diff;
    logic             upd_reject;
    logic [BAL_W-1:0] upd_result;

    assign old_locked = mem_rdata[BAL_W];
    assign old_bal    = mem_rdata[BAL_W-1:0];
    // one extra bit so a deposit overflow shows up as sum[BAL_W]
    assign sum        = {1'b0, old_bal} + {1'b0, amt_q};
    assign diff       = old_bal - amt_q;
    assign upd_reject = old_locked | (wd_q ? (amt_q > old_bal) : sum[BAL_W]);
    assign upd_result = wd_q ? diff : sum[BAL_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LOCK;
            id_q        <= '0;
            amt_q       <= '0;
            wd_q        <= 1'b0;
            rr_q        <= 1'b0;
            wdata_q     <= '0;
            ok_q        <= 1'b0;
            rd_bal_q    <= '0;
            rd_locked_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            id_q        <= id_d;
            amt_q       <= amt_d;
            wd_q        <= wd_d;
            rr_q        <= rr_d;
            wdata_q     <= wdata_d;
            ok_q        <= ok_d;
            rd_bal_q    <= rd_bal_d;
            rd_locked_q <= rd_locked_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        id_d        = id_q;
        amt_d       = amt_q;
        wd_d        = wd_q;
        rr_d        = rr_q;
        wdata_d     = wdata_q;
        ok_d        = ok_q;
        rd_bal_d    = rd_bal_q;
        rd_locked_d = rd_locked_q;
        case (state_q)
            S_IDLE: begin
                if (lock_req) begin
                    op_d    = OP_LOCK;
                    id_d    = lock_id;
                    state_d = S_RD;
                end else if (upd_req && (!rd_req || !rr_q)) begin
                    op_d    = OP_UPD;
                    id_d    = upd_id;
                    amt_d   = upd_amt;
                    wd_d    = upd_wd;
                    rr_d    = ~rr_q;
                    state_d = S_RD;
                end else if (rd_req) begin
                    op_d    = OP_RD;
                    id_d    = rd_id;
                    rr_d    = ~rr_q;
                    state_d = S_RD;
                end
            end
            S_RD: state_d = S_CALC;
            S_CALC: begin
                case (op_q)
                    OP_LOCK: begin
                        // lock is rewritten even if already set
                        wdata_d = {1'b1, old_bal};
                        state_d = S_WR;
                    end
                    OP_UPD: begin
                        wdata_d = {old_locked, upd_result};
                        ok_d    = ~upd_reject;
                        state_d = upd_reject ? S_DONE : S_WR;
                    end
                    default: begin
                        rd_bal_d    = old_bal;
                        rd_locked_d = old_locked;
                        state_d     = S_DONE;
                    end
                endcase
            end
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_en    = (state_q == S_RD) || (state_q == S_WR);
        mem_we    = (state_q == S_WR);
        mem_addr  = mem_en ? id_q : '0;
        mem_wdata = mem_we ? wdata_q : '0;
        lock_done = (state_q == S_DONE) && (op_q == OP_LOCK);
        upd_done  = (state_q == S_DONE) && (op_q == OP_UPD);
        upd_ok    = upd_done && ok_q;
        rd_done   = (state_q == S_DONE) && (op_q == OP_RD);
        rd_bal    = rd_bal_q;
        rd_locked = rd_locked_q;
    end

endmodule

// File: tb/tb_account_mem_arbiter.sv
// Testbench for account_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a transaction-level
// model of the accounts and arbitration rules.

module tb_account_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lock_req = 1'b0, upd_req = 1'b0, rd_req = 1'b0, upd_wd = 1'b0;
    logic [3:0]  lock_id = '0, upd_id = '0, rd_id = '0;
    logic [15:0] upd_amt = '0;
    logic        lock_done, upd_done, upd_ok, rd_done, rd_locked, mem_en, mem_we;
    logic [15:0] rd_bal;
    logic [3:0]  mem_addr;
    logic [16:0] mem_wdata;
    logic [16:0] mem_rdata = '0;

    always #5 clk = ~clk;

    account_mem_arbiter #(.ACC_W(4), .BAL_W(16)) dut (
        .clk(clk), .rst(rst),
        .lock_req(lock_req), .lock_id(lock_id), .lock_done(lock_done),
        .upd_req(upd_req), .upd_id(upd_id), .upd_amt(upd_amt), .upd_wd(upd_wd),
        .upd_done(upd_done), .upd_ok(upd_ok),
        .rd_req(rd_req), .rd_id(rd_id), .rd_done(rd_done),
        .rd_bal(rd_bal), .rd_locked(rd_locked),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // environment memory with a preload path for the bench
    logic [16:0] env_mem [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_addr = '0;
    logic [16:0] pl_data = '0;
    int          we_cnt = 0;

    always @(posedge clk) begin
        if (pl_en) env_mem[pl_addr] <= pl_data;
        else if (mem_en) begin
            if (mem_we) env_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= env_mem[mem_addr];
        end
        if (mem_en && mem_we) we_cnt <= we_cnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // transaction-level model
    logic [15:0] sh_bal [16];
    logic        sh_lock [16];
    bit          m_busy = 0, m_cool = 0, m_rr = 0, m_wr = 0, m_ok = 0;
    int          m_op = 0, m_cnt = 0, m_lat = 0, m_done_op = -1;
    logic [3:0]  m_id = '0;
    logic [16:0] m_word = '0;
    logic [15:0] m_rdbal = '0;
    logic        m_rdlk = 1'b0;
    bit          waiting [3];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({lock_done, upd_done, upd_ok, rd_done, rd_locked, rd_bal,
                    mem_en, mem_we, mem_addr, mem_wdata});
    endfunction

    task automatic model_reset();
        m_busy = 0; m_cool = 0; m_rr = 0; m_rdbal = '0; m_rdlk = 1'b0; m_done_op = -1;
    endtask

    // decide what the block grants at the coming edge from the current requests
    task automatic model_grant();
        int op, b, a, s;
        if (m_cool) begin m_cool = 0; return; end
        if (m_busy) return;
        if (lock_req) op = 0;
        else if (upd_req && rd_req) op = m_rr ? 2 : 1;
        else if (upd_req) op = 1;
        else if (rd_req) op = 2;
        else return;
        if (op != 0) m_rr = !m_rr;
        m_op = op; m_busy = 1; m_cnt = 0; m_ok = 1;
        case (op)
            0: begin
                m_id = lock_id; m_wr = 1; m_lat = 4;
                m_word = {1'b1, sh_bal[lock_id]};
            end
            1: begin
                m_id = upd_id;
                b = int'(sh_bal[upd_id]);
                a = int'(upd_amt);
                s = b;
                if (sh_lock[upd_id]) m_ok = 0;
                else if (upd_wd) begin m_ok = (a <= b); s = b - a; end
                else begin s = b + a; m_ok = (s <= 65535); end
                m_wr = m_ok;
                m_lat = m_ok ? 4 : 3;
                m_word = {sh_lock[upd_id], s[15:0]};
            end
            default: begin
                m_id = rd_id; m_wr = 0; m_lat = 3;
                m_word = {sh_lock[rd_id], sh_bal[rd_id]};
            end
        endcase
    endtask

    task automatic compare();
        logic e_en, e_we, ldn, udn, rdn;
        e_en = 0; e_we = 0; ldn = 0; udn = 0; rdn = 0;
        if (m_busy) begin
            m_cnt++;
            if (m_cnt == 1) e_en = 1;
            if (m_cnt == 3 && m_wr) begin e_en = 1; e_we = 1; end
            if (m_cnt == m_lat) begin
                case (m_op)
                    0: ldn = 1;
                    1: udn = 1;
                    default: begin
                        rdn = 1;
                        m_rdbal = m_word[15:0];
                        m_rdlk  = m_word[16];
                    end
                endcase
                if (m_wr) begin
                    sh_bal[m_id]  = m_word[15:0];
                    sh_lock[m_id] = m_word[16];
                end
                m_done_op = m_op; m_busy = 0; m_cool = 1;
            end
        end
        chk("strobes", 64'({mem_en, mem_we, lock_done, upd_done, rd_done}),
            64'({e_en, e_we, ldn, udn, rdn}));
        if (e_en) chk("mem_addr", 64'(mem_addr), 64'(m_id));
        if (e_we) chk("mem_wdata", 64'(mem_wdata), 64'(m_word));
        if (udn)  chk("upd_ok", 64'(upd_ok), 64'(m_ok));
        chk("rd_data", 64'({rd_locked, rd_bal}), 64'({m_rdlk, m_rdbal}));
    endtask

    task automatic step();
        if (!rst) model_grant();
        @(negedge clk);
        cyc++;
        m_done_op = -1;
        if (!rst) compare();
    endtask

    task automatic apply_reset();
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", out_vec(), 64'd0);
        model_reset();
        lock_req = 0; upd_req = 0; rd_req = 0;
        for (int i = 0; i < 3; i++) waiting[i] = 0;
        @(negedge clk); @(negedge clk);
        cyc += 2;
        rst = 1'b0;
    endtask

    task automatic preload(input int a, input logic lk, input logic [15:0] bal);
        pl_en = 1'b1; pl_addr = a[3:0]; pl_data = {lk, bal};
        sh_bal[a] = bal; sh_lock[a] = lk;
        step();
        pl_en = 1'b0;
    endtask

    task automatic wait_done(input int op, input int budget, output int dcyc, output logic ok);
        dcyc = -1; ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step();
            if ((op == 0 && lock_done) || (op == 1 && upd_done) || (op == 2 && rd_done)) begin
                dcyc = cyc; ok = upd_ok;
                if (op == 0) lock_req = 0; else if (op == 1) upd_req = 0; else rd_req = 0;
                break;
            end
        end
        if (dcyc < 0) begin
            n_tests++; n_fail++;
            $display("FAIL wait_done op %0d: no done pulse within %0d cycles", op, budget);
        end
    endtask

    initial begin
        int rc, dc, n, wc, seen;
        logic ok;
        int ord [4];

        model_reset();
        @(negedge clk); @(negedge clk);
        cyc = 2;
        chk("reset_outputs", out_vec(), 64'd0);
        rst = 1'b0;

        for (int a = 0; a < 16; a++)
            preload(a, 1'b0, ($urandom_range(0, 3) == 0) ? 16'($urandom_range(65500, 65535))
                                                         : 16'($urandom_range(0, 65535)));

        // deposit 50 into 100
        preload(3, 1'b0, 16'd100);
        upd_id = 3; upd_amt = 16'd50; upd_wd = 0; upd_req = 1; rc = cyc;
        wait_done(1, 20, dc, ok);
        chk("dep50_latency", 64'(dc - rc), 64'd4);
        chk("dep50_ok", 64'(ok), 64'd1);
        chk("dep50_mem", 64'(env_mem[3]), 64'd150);

        // withdraw 101 from 100 rejected, then withdraw 100
        preload(3, 1'b0, 16'd100);
        wc = we_cnt;
        upd_id = 3; upd_amt = 16'd101; upd_wd = 1; upd_req = 1; rc = cyc;
        wait_done(1, 20, dc, ok);
        chk("wd101_latency", 64'(dc - rc), 64'd3);
        chk("wd101_ok", 64'(ok), 64'd0);
        chk("wd101_no_write", 64'(we_cnt - wc), 64'd0);
        step();
        upd_amt = 16'd100; upd_req = 1; rc = cyc;
        wait_done(1, 20, dc, ok);
        chk("wd100_latency", 64'(dc - rc), 64'd4);
        chk("wd100_ok", 64'(ok), 64'd1);
        chk("wd100_mem", 64'(env_mem[3]), 64'd0);

        // overflow reject, lock, read back
        preload(5, 1'b0, 16'hFFFF);
        wc = we_cnt;
        upd_id = 5; upd_amt = 16'd1; upd_wd = 0; upd_req = 1; rc = cyc;
        wait_done(1, 20, dc, ok);
        chk("ovf_latency", 64'(dc - rc), 64'd3);
        chk("ovf_ok", 64'(ok), 64'd0);
        chk("ovf_no_write", 64'(we_cnt - wc), 64'd0);
        step();
        lock_id = 5; lock_req = 1; rc = cyc;
        wait_done(0, 20, dc, ok);
        chk("lock_latency", 64'(dc - rc), 64'd4);
        chk("lock_mem", 64'(env_mem[5]), 64'h1FFFF);
        step();
        rd_id = 5; rd_req = 1; rc = cyc;
        wait_done(2, 20, dc, ok);
        chk("read_latency", 64'(dc - rc), 64'd3);
        chk("read_bal", 64'(rd_bal), 64'hFFFF);
        chk("read_locked", 64'(rd_locked), 64'd1);
        step();

        // simultaneous lock/update/read from a fresh pointer
        apply_reset();
        preload(2, 1'b0, 16'd500);
        lock_id = 1; upd_id = 2; upd_amt = 16'd1; upd_wd = 0; rd_id = 2;
        lock_req = 1; upd_req = 1; rd_req = 1;
        n = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            step();
            if (lock_done && n < 3) begin ord[n] = 0; n++; lock_req = 0; end
            if (upd_done && n < 3)  begin ord[n] = 1; n++; upd_req = 0; end
            if (rd_done && n < 3)   begin ord[n] = 2; n++; rd_req = 0; end
        end
        chk("prio_count", 64'(n), 64'd3);
        chk("prio_first", 64'(ord[0]), 64'd0);
        chk("prio_second", 64'(ord[1]), 64'd1);
        chk("prio_third", 64'(ord[2]), 64'd2);
        chk("prio_read_bal", 64'(rd_bal), 64'd501);
        step();

        // continuous update and read requests alternate
        preload(4, 1'b0, 16'd1000);
        upd_id = 4; upd_amt = 16'd1; upd_wd = 0; rd_id = 4;
        upd_req = 1; rd_req = 1;
        n = 0;
        for (int k = 0; k < 60 && n < 4; k++) begin
            step();
            if (upd_done) begin ord[n] = 1; n++; end
            else if (rd_done) begin ord[n] = 2; n++; end
        end
        upd_req = 0; rd_req = 0;
        chk("alt_count", 64'(n), 64'd4);
        chk("alt_pattern", 64'({ord[0][1:0], ord[1][1:0], ord[2][1:0], ord[3][1:0]}), 64'b01_10_01_10);
        repeat (6) step();

        // reset during CALC of an accepted deposit
        preload(7, 1'b0, 16'd10);
        upd_id = 7; upd_amt = 16'd5; upd_wd = 0; upd_req = 1;
        step();
        step();
        wc = we_cnt;
        upd_req = 0;
        apply_reset();
        seen = 0;
        repeat (6) begin
            step();
            if (upd_done) seen = 1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        chk("abort_no_write", 64'(we_cnt - wc), 64'd0);
        chk("abort_mem", 64'(env_mem[7]), 64'd10);
        chk("abort_idle_outputs", out_vec(), 64'd0);

        // randomized traffic
        for (int i = 0; i < 3; i++) waiting[i] = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (m_done_op == 0) begin lock_req = 0; waiting[0] = 0; end
            if (m_done_op == 1) begin upd_req = 0; waiting[1] = 0; end
            if (m_done_op == 2) begin rd_req = 0; waiting[2] = 0; end
            if (m_busy && m_cnt >= 1) begin
                // inputs of the granted requester change; must be ignored
                if (m_op == 1 && upd_req) begin
                    upd_amt = 16'($urandom); upd_id = 4'($urandom); upd_wd = 1'($urandom);
                    if (m_cnt == 1 && $urandom_range(0, 3) == 0) upd_req = 0;
                end
                if (m_op == 2 && rd_req) rd_id = 4'($urandom);
            end
            if (!waiting[0] && $urandom_range(0, 15) == 0) begin
                lock_id = {1'b1, 3'($urandom)}; lock_req = 1; waiting[0] = 1;
            end
            if (!waiting[1] && $urandom_range(0, 2) == 0) begin
                upd_id = 4'($urandom); upd_wd = 1'($urandom);
                upd_amt = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
                upd_req = 1; waiting[1] = 1;
            end
            if (!waiting[2] && $urandom_range(0, 2) == 0) begin
                rd_id = 4'($urandom); rd_req = 1; waiting[2] = 1;
            end
            if ($urandom_range(0, 399) == 0) apply_reset();
        end

        // drain
        n = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (m_done_op == 0) begin lock_req = 0; waiting[0] = 0; end
            if (m_done_op == 1) begin upd_req = 0; waiting[1] = 0; end
            if (m_done_op == 2) begin rd_req = 0; waiting[2] = 0; end
            if (!m_busy && !m_cool && !waiting[0] && !waiting[1] && !waiting[2]) begin
                n = 1;
                break;
            end
        end
        if (n == 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: traffic did not complete within 100 cycles");
        end
        for (int a = 0; a < 16; a++)
            chk("final_mem", 64'(env_mem[a]), 64'({sh_lock[a], sh_bal[a]}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/account_mem_arbiter.md
ACCOUNT_MEM_ARBITER -- requirements
Module: account_mem_arbiter

Interface
REQ-001 Parameter ACC_W, default 4: account index width (2**ACC_W accounts).
REQ-002 Parameter BAL_W, default 16: balance width; memory word is {locked, balance}, BAL_W+1 bits.
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 lock_req  in  1  request to set the lock bit of lock_id; held until lock_done.
REQ-006 lock_id  in  ACC_W  account to lock.
REQ-007 lock_done  out  1  one-cycle pulse when the lock write has completed.
REQ-008 upd_req  in  1  balance-update request; held until upd_done.
REQ-009 upd_id  in  ACC_W  account to update.
REQ-010 upd_amt  in  BAL_W  unsigned amount.
REQ-011 upd_wd  in  1  1 = withdraw (subtract), 0 = deposit (add).
REQ-012 upd_done  out  1  one-cycle pulse ending an update.
REQ-013 upd_ok  out  1  valid with upd_done: 1 = written, 0 = rejected.
REQ-014 rd_req  in  1  balance-query request; held until rd_done.
REQ-015 rd_id  in  ACC_W  account to read.
REQ-016 rd_done  out  1  one-cycle pulse; rd_bal/rd_locked valid.
REQ-017 rd_bal  out  BAL_W  balance read; holds until the next rd_done.
REQ-018 rd_locked  out  1  lock bit read; holds until the next rd_done.
REQ-019 mem_en  out  1  single-port memory enable.
REQ-020 mem_we  out  1  write enable; only asserted together with mem_en.
REQ-021 mem_addr  out  ACC_W  memory address.
REQ-022 mem_wdata  out  BAL_W+1  write word {locked, balance}.
REQ-023 mem_rdata  in  BAL_W+1  read word, valid the cycle after a read mem_en.

Function
REQ-024 FSM states: IDLE, RD, CALC, WR, DONE; exactly one operation in flight at a time.
REQ-025 In IDLE the block samples requests. Priority: lock_req is highest. Between upd_req and rd_req, a round-robin pointer decides; it toggles after each serviced update or read. The pointer favours update after reset.
REQ-026 On grant, the id, amount and direction are latched and the next state is RD. Input changes after grant are ignored.
REQ-027 RD: mem_en=1, mem_we=0, mem_addr=latched id.
REQ-028 CALC: mem_rdata is captured and the result computed.
  - Read goes to DONE.
  - Lock and update go to WR, or to DONE if rejected.
REQ-029 Lock: new word = {1, old balance}; the write is always performed, including when the account is already locked.
REQ-030 Update rejection (no write, upd_ok=0) occurs on any of:
  - account locked;
  - withdraw with upd_amt > balance;
  - deposit where balance+upd_amt exceeds 2**BAL_W-1. The sum is evaluated at BAL_W+1 bits.
REQ-031 Update acceptance: balance +/- upd_amt is written with the lock bit unchanged, and upd_ok=1. upd_amt=0 is accepted and rewrites the same value.
REQ-032 WR: mem_en=1, mem_we=1, mem_addr=latched id, mem_wdata=new word; then DONE.
REQ-033 DONE: exactly one of lock_done/upd_done/rd_done is high for one cycle, then IDLE. A new grant cannot occur before the next IDLE cycle.
REQ-034 Latency from the grant edge to the done pulse:
  - update/lock with write: 4 cycles;
  - rejected update: 3 cycles;
  - read: 3 cycles.
REQ-035 Dropping a request before its done does not abort the latched operation; the done pulse still occurs.
REQ-036 Outside RD/WR, mem_en=0 and mem_we=0. mem_addr and mem_wdata are don't-care when mem_en=0.

Reset
REQ-037 rst forces IDLE and the round-robin pointer to update. All outputs go to 0, including rd_bal and rd_locked, immediately and without waiting for clk.
REQ-038 A reset during RD/CALC/WR aborts the operation: no write is issued after reset and no done pulse is generated.

Verification
REQ-039 Account 3 = {0,100}; update deposit 50 -> write {0,150} to addr 3; upd_done with upd_ok=1 four cycles after grant.
REQ-040 Account 3 = {0,100}; withdraw 101 -> no mem_we; upd_ok=0 three cycles after grant. Then withdraw 100 -> write {0,0}, upd_ok=1.
REQ-041 Account 5 = {0,FFFF}; deposit 1 -> rejected, no write. Lock account 5 -> write {1,FFFF}. Then read 5 -> rd_bal=FFFF, rd_locked=1.
REQ-042 lock_req, upd_req and rd_req all asserted in the same cycle -> order of service is lock, update, read, with each done pulse in that order.
REQ-043 Continuous upd_req and rd_req -> grants alternate update, read, update, read.
REQ-044 Assert rst during the CALC of an accepted deposit -> mem_we never asserted, no upd_done; after release, the FSM is in IDLE and all outputs are 0.
